// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch buffer between instruction memory and the fetch stage.
//
// The block issues sequential word reads starting at RESET_PC. It queues each returned word
// with its address in a DEPTH-entry FIFO. A flush redirects fetching to a new address. If a
// read is still outstanding when the flush arrives, the block waits for that read in DROP and
// throws its data away before fetching from the new target.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   flush, flush_pc    redirect request and new fetch address (low two bits ignored)
//   mem_req, mem_addr  memory read request and its word address (registered)
//   mem_ack, mem_rdata memory accepts the request; read data arrives in the same cycle
//   out_valid          head entry available
//   out_instr, out_pc  head instruction and its address
//   out_ready          fetch stage consumes the head
//   level              number of valid entries, 0..DEPTH
module prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_ack,
    input  logic [31:0]                mem_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fa_q, fa_d;
    logic [31:0]   redirect_q, redirect_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   flush_target;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^flush_pc[1:0];

    always_comb begin
        state_d      = state_q;
        fa_d         = fa_q;
        redirect_d   = redirect_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        push         = 1'b0;
        flush_target = {flush_pc[31:2], 2'b00};
        pop          = (level_q != '0) && out_ready && !flush;

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    fa_d    = flush_target;
                    state_d = StReq;
                end else if (level_q < FULL) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    if (mem_ack) begin
                        // The acked word belongs to the old path; drop it and refetch at once.
                        fa_d = flush_target;
                    end else begin
                        // mem_addr must stay put until the outstanding read is acked.
                        redirect_d = flush_target;
                        state_d    = StDrop;
                    end
                end else if (mem_ack) begin
                    push = (level_q != FULL);
                    fa_d = fa_q + 32'd4;
                end
            end
            StDrop: begin
                if (flush) begin
                    redirect_d = flush_target;
                end
                if (mem_ack) begin
                    fa_d    = flush ? flush_target : redirect_q;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        // Stop requesting once the push fills the FIFO.
        if (state_q == StReq && !flush && mem_ack && level_d == FULL) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            fa_q       <= RESET_PC;
            redirect_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            redirect_q <= redirect_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset; level gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fa_q;
            instr_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign mem_addr  = fa_q;
    assign out_valid = (level_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  level;

    int n_pass;
    int n_total;

    prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word encodes its own address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    assign mem_rdata = word_at(mem_addr);

    typedef struct {
        logic        rst;
        logic        fl;
        logic [31:0] fpc;
        logic        ack;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic [2:0]  elvl;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic fl, input logic [31:0] fpc,
                       input logic ack, input logic rdy, input logic ereq,
                       input logic [31:0] eaddr, input logic [2:0] elvl,
                       input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.fpc = fpc; v.ack = ack; v.rdy = rdy;
        v.ereq = ereq; v.eaddr = eaddr; v.elvl = elvl; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                               input logic [2:0] elvl, input logic [31:0] epc);
        chk({tag, " mem_req"},   32'(mem_req),   32'(ereq));
        chk({tag, " mem_addr"},  mem_addr,       eaddr);
        chk({tag, " level"},     32'(level),     32'(elvl));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(elvl != 3'd0));
        if (elvl != 3'd0) begin
            chk({tag, " out_pc"},    out_pc,    epc);
            chk({tag, " out_instr"}, out_instr, word_at(epc));
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        mem_ack   = 1'b1;
        out_ready = 1'b0;

        //   rst fl fpc        ack rdy | req addr         lvl pc
        add(1, 0, 32'h0,     1, 0,   0, 32'h0,       0, 32'h0);   // ack ignored in reset
        add(1, 0, 32'h0,     1, 0,   0, 32'h0,       0, 32'h0);
        // Fill from reset, no consumer.
        add(0, 0, 32'h0,     1, 0,   1, 32'h0,       0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h4,       1, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h8,       2, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'hC,       3, 32'h0);
        add(0, 0, 32'h0,     1, 0,   0, 32'h10,      4, 32'h0);
        add(0, 0, 32'h0,     1, 0,   0, 32'h10,      4, 32'h0);
        // One pop from full, then refill.
        add(0, 0, 32'h0,     1, 1,   0, 32'h10,      3, 32'h4);
        add(0, 0, 32'h0,     1, 0,   1, 32'h10,      3, 32'h4);
        add(0, 0, 32'h0,     1, 0,   0, 32'h14,      4, 32'h4);
        // Drain into streaming at constant level.
        add(0, 0, 32'h0,     1, 1,   0, 32'h14,      3, 32'h8);
        add(0, 0, 32'h0,     1, 1,   1, 32'h14,      2, 32'hC);
        add(0, 0, 32'h0,     1, 1,   1, 32'h18,      2, 32'h10);
        add(0, 0, 32'h0,     1, 1,   1, 32'h1C,      2, 32'h14);
        add(0, 0, 32'h0,     1, 1,   1, 32'h20,      2, 32'h18);
        // Flush together with ack: word discarded, pop ignored.
        add(0, 1, 32'h40,    1, 1,   1, 32'h40,      0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h44,      1, 32'h40);
        add(0, 0, 32'h0,     0, 0,   1, 32'h44,      1, 32'h40);
        // Reset, fetch two words, then flush with a pending request at 8.
        add(1, 0, 32'h0,     0, 0,   0, 32'h0,       0, 32'h0);
        add(0, 0, 32'h0,     0, 0,   1, 32'h0,       0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h4,       1, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h8,       2, 32'h0);
        add(0, 1, 32'h103,   0, 0,   1, 32'h8,       0, 32'h0);
        add(0, 0, 32'h0,     0, 0,   1, 32'h8,       0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h100,     0, 32'h0);   // ack for 8 dropped
        add(0, 0, 32'h0,     1, 0,   1, 32'h104,     1, 32'h100);
        // Two flushes while draining: the later target wins.
        add(0, 1, 32'h300,   0, 0,   1, 32'h104,     0, 32'h0);
        add(0, 1, 32'h502,   0, 0,   1, 32'h104,     0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h500,     0, 32'h0);
        add(0, 0, 32'h0,     1, 0,   1, 32'h504,     1, 32'h500);
        add(0, 0, 32'h0,     1, 0,   1, 32'h508,     2, 32'h500);
        add(0, 0, 32'h0,     1, 0,   1, 32'h50C,     3, 32'h500);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            flush_pc  = vecs[i].fpc;
            mem_ack   = vecs[i].ack;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr,
                        vecs[i].elvl, vecs[i].epc);
        end

        // Asynchronous reset between edges with level=3 and a request pending at 0x50C.
        @(negedge clk);
        flush     = 1'b0;
        mem_ack   = 1'b1;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_outputs("async_rst", 1'b0, 32'h0, 3'd0, 32'h0);
        @(posedge clk);
        #1;
        chk_outputs("rst_hold", 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("refetch_req", 1'b1, 32'h0, 3'd0, 32'h0);
        @(posedge clk);
        #1;
        chk_outputs("refetch_word", 1'b1, 32'h4, 3'd1, 32'h0);

        // Flush while idle and full: go straight to the new target.
        @(negedge clk);
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("refill_full", 1'b0, 32'h10, 3'd4, 32'h0);
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 32'h801;
        @(posedge clk);
        #1;
        chk_outputs("idle_flush", 1'b1, 32'h800, 3'd0, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("idle_flush_word", 1'b1, 32'h804, 3'd1, 32'h800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
